// File: rtl/signal_watchdog_mc_pkg.sv
// Shared definitions for the receive-signal watchdog.
//   wd_state_t      : watchdog FSM encoding, also the wd_state debug output
//   REASON_*        : bit positions in monitor_mask and rst_reason
//   S_DECODE_SIGNAL : receiver state in which the equalizer monitor runs
//   abs17           : magnitude of a 16-bit signed value (-32768 -> 32768)
package signal_watchdog_mc_pkg;

    typedef enum logic [1:0] {
        WD_IDLE     = 2'd0,
        WD_ARMED    = 2'd1,
        WD_HOLD     = 2'd2,
        WD_COOLDOWN = 2'd3
    } wd_state_t;

    localparam int REASON_DC    = 0;
    localparam int REASON_LEN   = 1;
    localparam int REASON_EQ    = 2;
    localparam int REASON_PHASE = 3;

    localparam logic [4:0] S_DECODE_SIGNAL = 5'd6;

    // Widen before negating so the most negative input has a representable magnitude.
    function automatic logic [16:0] abs17(input logic [15:0] v);
        logic signed [16:0] wide;
        wide = $signed({v[15], v});
        return v[15] ? 17'(-wide) : 17'(wide);
    endfunction

endpackage

// File: rtl/signal_watchdog_mc_sign_running_sum.sv
// Sign running sum for one I or Q component.
// Each accepted sample contributes +1 (positive), -1 (negative) or the shared
// dither value (zero). The sum covers the last 2^LOG2_LEN accepted samples.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   valid     : sample strobe; nothing moves when low
//   dither    : 1 = a zero sample counts +1, 0 = counts -1
//   sample    : signed sample
//   sum       : signed running sum, LOG2_LEN+2 bits
module signal_watchdog_mc_sign_running_sum #(
    parameter int W        = 16,
    parameter int LOG2_LEN = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic                  dither,
    input  logic [W-1:0]          sample,
    output logic [LOG2_LEN+1:0]   sum
);

    localparam int LEN = 1 << LOG2_LEN;

    // Two-bit signed sign per slot: 01 = +1, 11 = -1, 00 = empty slot after reset.
    logic [1:0] line [LEN];
    logic [1:0] new_sign;
    logic [1:0] old_sign;

    always_comb begin
        if (sample == '0)
            new_sign = dither ? 2'b01 : 2'b11;
        else if (sample[W-1])
            new_sign = 2'b11;
        else
            new_sign = 2'b01;
    end

    assign old_sign = line[LEN-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
            for (int i = 0; i < LEN; i++) line[i] <= 2'b00;
        end else if (valid) begin
            sum <= sum + {{LOG2_LEN{new_sign[1]}}, new_sign}
                       - {{LOG2_LEN{old_sign[1]}}, old_sign};
            line[0] <= new_sign;
            for (int i = 1; i < LEN; i++) line[i] <= line[i-1];
        end
    end

endmodule

// File: rtl/signal_watchdog_mc.sv
// Multi-channel receive-signal watchdog.
// Watches four causes (DC offset, signal length, small equalizer output, large
// phase offset) and, while armed, pulses receiver_rst for RST_HOLD_LEN cycles
// followed by a COOLDOWN_LEN cycle blind period.
// Strobes (iq_valid, sig_valid, equalizer_valid) are valid-only: data is taken
// in any cycle where the strobe is high; there is no ready/back-pressure.
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   enable, power_trigger          : watchdog enable, packet energy present
//   iq_data, iq_valid              : per channel {I,Q}, channel 0 in LSBs
//   ch_mask, monitor_mask          : DC channel selection, cause enables
//   signal_len, sig_valid, *_len_th: length check
//   dc_running_sum_th              : signed DC threshold
//   state, equalizer(_valid), small_eq_out_counter_th : equalizer monitor
//   phase_offset, short_preamble_detected, phase_offset_abs_th : phase monitor
//   receiver_rst, rst_reason, rst_count, dc_ch_flag, wd_state : outputs
module signal_watchdog_mc
    import signal_watchdog_mc_pkg::*;
#(
    parameter int IQ_DATA_WIDTH = 16,
    parameter int NUM_CH        = 2,
    parameter int LOG2_SUM_LEN  = 6,
    parameter int DC_COMBINE    = 0,
    parameter int RST_HOLD_LEN  = 4,
    parameter int COOLDOWN_LEN  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          power_trigger,
    input  logic [NUM_CH*2*IQ_DATA_WIDTH-1:0] iq_data,
    input  logic                          iq_valid,
    input  logic [NUM_CH-1:0]             ch_mask,
    input  logic [3:0]                    monitor_mask,
    input  logic [15:0]                   signal_len,
    input  logic                          sig_valid,
    input  logic [15:0]                   min_signal_len_th,
    input  logic [15:0]                   max_signal_len_th,
    input  logic [LOG2_SUM_LEN+1:0]       dc_running_sum_th,
    input  logic [4:0]                    state,
    input  logic [31:0]                   equalizer,
    input  logic                          equalizer_valid,
    input  logic [5:0]                    small_eq_out_counter_th,
    input  logic [15:0]                   phase_offset,
    input  logic                          short_preamble_detected,
    input  logic [16:0]                   phase_offset_abs_th,
    output logic                          receiver_rst,
    output logic [3:0]                    rst_reason,
    output logic [15:0]                   rst_count,
    output logic [NUM_CH-1:0]             dc_ch_flag,
    output logic [1:0]                    wd_state
);

    localparam int SUM_W = LOG2_SUM_LEN + 2;
    localparam logic [15:0] HOLD_LAST = 16'(RST_HOLD_LEN - 1);
    localparam logic [15:0] COOL_LAST = 16'(COOLDOWN_LEN - 1);

    // ---------------- DC monitor ----------------
    logic dither_pos;
    // Component k = 2*c is channel c Q, k = 2*c+1 is channel c I (matches iq_data packing).
    logic [2*NUM_CH-1:0][SUM_W-1:0] sums;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           dither_pos <= 1'b1;
        else if (iq_valid) dither_pos <= ~dither_pos;
    end

    for (genvar k = 0; k < 2 * NUM_CH; k++) begin : g_sum
        signal_watchdog_mc_sign_running_sum #(
            .W        (IQ_DATA_WIDTH),
            .LOG2_LEN (LOG2_SUM_LEN)
        ) u_sign_running_sum (
            .clk    (clk),
            .rst    (rst),
            .valid  (iq_valid),
            .dither (dither_pos),
            .sample (iq_data[k*IQ_DATA_WIDTH +: IQ_DATA_WIDTH]),
            .sum    (sums[k])
        );
    end

    function automatic logic sum_over_th(input logic [SUM_W-1:0] s, input logic [SUM_W-1:0] th);
        logic signed [SUM_W-1:0] mag;
        mag = s[SUM_W-1] ? -$signed(s) : $signed(s);
        return mag >= $signed(th);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dc_ch_flag <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++)
                dc_ch_flag[c] <= sum_over_th(sums[2*c], dc_running_sum_th)
                              || sum_over_th(sums[2*c+1], dc_running_sum_th);
        end
    end

    logic [NUM_CH-1:0] dc_masked;
    logic              dc_cause;
    assign dc_masked = dc_ch_flag & ch_mask;
    assign dc_cause  = (ch_mask != '0) &&
                       ((DC_COMBINE != 0) ? (dc_masked == ch_mask) : (dc_masked != '0));

    // ---------------- length monitor ----------------
    logic len_cause;
    assign len_cause = sig_valid && ((signal_len < min_signal_len_th) ||
                                     (signal_len > max_signal_len_th));

    // ---------------- equalizer monitor ----------------
    logic        eq_active;
    logic [16:0] eq_abs_i, eq_abs_q;
    logic [5:0]  eq_cnt_i, eq_cnt_q;
    logic        eq_cause;

    assign eq_active = (state == S_DECODE_SIGNAL);

    // Counters look at the previous sample's magnitude, so they lag one sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || !eq_active) begin
            eq_abs_i <= '0;
            eq_abs_q <= '0;
            eq_cnt_i <= '0;
            eq_cnt_q <= '0;
        end else if (equalizer_valid) begin
            eq_abs_i <= abs17(equalizer[31:16]);
            eq_abs_q <= abs17(equalizer[15:0]);
            if (eq_abs_i <= 17'd2 && eq_cnt_i != 6'd63) eq_cnt_i <= eq_cnt_i + 6'd1;
            if (eq_abs_q <= 17'd2 && eq_cnt_q != 6'd63) eq_cnt_q <= eq_cnt_q + 6'd1;
        end
    end

    // Gated by eq_active so a zero threshold cannot fire outside S_DECODE_SIGNAL.
    assign eq_cause = eq_active && (eq_cnt_i >= small_eq_out_counter_th)
                                && (eq_cnt_q >= small_eq_out_counter_th);

    // ---------------- phase monitor ----------------
    logic phase_cause;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) phase_cause <= 1'b0;
        else     phase_cause <= short_preamble_detected &&
                                (abs17(phase_offset) > phase_offset_abs_th);
    end

    logic [3:0] cause_vec;
    always_comb begin
        cause_vec               = 4'b0000;
        cause_vec[REASON_DC]    = dc_cause;
        cause_vec[REASON_LEN]   = len_cause;
        cause_vec[REASON_EQ]    = eq_cause;
        cause_vec[REASON_PHASE] = phase_cause;
        cause_vec               = cause_vec & monitor_mask;
    end

    // ---------------- watchdog FSM ----------------
    wd_state_t   cur_st, nxt_st;
    logic [15:0] timer;
    logic        go;
    logic        hold_entry, rst_next, timer_restart;

    assign go = enable && power_trigger;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cur_st <= WD_IDLE;
        else     cur_st <= nxt_st;
    end

    always_comb begin
        nxt_st = cur_st;
        if (!enable) begin
            nxt_st = WD_IDLE;
        end else begin
            case (cur_st)
                WD_IDLE:     if (go) nxt_st = WD_ARMED;
                WD_ARMED:    if (!go) nxt_st = WD_IDLE;
                             else if (cause_vec != 4'b0000) nxt_st = WD_HOLD;
                WD_HOLD:     if (timer == HOLD_LAST) nxt_st = WD_COOLDOWN;
                WD_COOLDOWN: if (timer == COOL_LAST) nxt_st = go ? WD_ARMED : WD_IDLE;
                default:     nxt_st = WD_IDLE;
            endcase
        end
    end

    always_comb begin
        hold_entry    = (cur_st == WD_ARMED) && (nxt_st == WD_HOLD);
        rst_next      = (nxt_st == WD_HOLD);
        timer_restart = (nxt_st != cur_st);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            receiver_rst <= 1'b0;
            rst_reason   <= 4'b0000;
            rst_count    <= 16'd0;
            timer        <= 16'd0;
        end else begin
            receiver_rst <= rst_next;
            if (hold_entry) begin
                rst_reason <= cause_vec;
                if (rst_count != 16'hFFFF) rst_count <= rst_count + 16'd1;
            end
            if (timer_restart)
                timer <= 16'd0;
            else if (cur_st == WD_HOLD || cur_st == WD_COOLDOWN)
                timer <= timer + 16'd1;
        end
    end

    assign wd_state = cur_st;

endmodule

// File: tb/tb_signal_watchdog_mc.sv
module tb_signal_watchdog_mc;
    import signal_watchdog_mc_pkg::*;

    localparam int W          = 16;
    localparam int NCH        = 2;
    localparam int L2         = 6;
    localparam int DC_COMBINE = 0;
    localparam int HOLD_LEN   = 4;
    localparam int COOL_LEN   = 16;
    localparam int WIN        = 1 << L2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                 enable, power_trigger, iq_valid, sig_valid, eq_valid, spd;
    logic [NCH*2*W-1:0]   iq_data;
    logic [NCH-1:0]       ch_mask;
    logic [3:0]           monitor_mask;
    logic [15:0]          signal_len, min_th, max_th, phase_offset;
    logic [L2+1:0]        dc_th;
    logic [4:0]           rx_state;
    logic [31:0]          equalizer;
    logic [5:0]           eq_th;
    logic [16:0]          ph_th;
    logic                 receiver_rst;
    logic [3:0]           rst_reason;
    logic [15:0]          rst_count;
    logic [NCH-1:0]       dc_ch_flag;
    logic [1:0]           wd_state;

    signal_watchdog_mc #(
        .IQ_DATA_WIDTH(W), .NUM_CH(NCH), .LOG2_SUM_LEN(L2), .DC_COMBINE(DC_COMBINE),
        .RST_HOLD_LEN(HOLD_LEN), .COOLDOWN_LEN(COOL_LEN)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .power_trigger(power_trigger),
        .iq_data(iq_data), .iq_valid(iq_valid), .ch_mask(ch_mask), .monitor_mask(monitor_mask),
        .signal_len(signal_len), .sig_valid(sig_valid), .min_signal_len_th(min_th),
        .max_signal_len_th(max_th), .dc_running_sum_th(dc_th), .state(rx_state),
        .equalizer(equalizer), .equalizer_valid(eq_valid), .small_eq_out_counter_th(eq_th),
        .phase_offset(phase_offset), .short_preamble_detected(spd), .phase_offset_abs_th(ph_th),
        .receiver_rst(receiver_rst), .rst_reason(rst_reason), .rst_count(rst_count),
        .dc_ch_flag(dc_ch_flag), .wd_state(wd_state)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Sign history per component (index 2*c = channel c I, 2*c+1 = channel c Q),
    // summed directly; FSM as a mode plus cycles-remaining countdown.
    int       m_hist [2*NCH][$];
    int       m_dither = 1;
    bit [1:0] m_flag = '0;
    int       m_abs_i = 0, m_abs_q = 0, m_cnt_i = 0, m_cnt_q = 0;
    bit       m_ph = 1'b0;
    int       m_mode = 0, m_left = 0, m_count = 0;
    bit [3:0] m_reason = '0;
    bit       m_go, m_dcc, m_lenc, m_eqa, m_eqc;
    bit [1:0] m_masked, m_flag_nxt;
    bit [3:0] m_cause;
    int       m_v, m_s;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int comp_sum(input int k);
        int s = 0;
        for (int i = 0; i < m_hist[k].size(); i++) s += m_hist[k][i];
        return s;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2*NCH; k++) m_hist[k].delete();
            m_dither = 1; m_flag = '0;
            m_abs_i = 0; m_abs_q = 0; m_cnt_i = 0; m_cnt_q = 0; m_ph = 1'b0;
            m_mode = 0; m_left = 0; m_count = 0; m_reason = '0;
        end else begin
            // causes from the values held before this edge
            m_masked = m_flag & ch_mask;
            m_dcc    = 1'b0;
            if (ch_mask != 0) m_dcc = (DC_COMBINE != 0) ? (m_masked == ch_mask) : (m_masked != 0);
            m_lenc   = sig_valid && (signal_len < min_th || signal_len > max_th);
            m_eqa    = (rx_state == S_DECODE_SIGNAL);
            m_eqc    = m_eqa && m_cnt_i >= int'(eq_th) && m_cnt_q >= int'(eq_th);
            m_cause  = {m_ph, m_eqc, m_lenc, m_dcc} & monitor_mask;
            m_go     = enable && power_trigger;

            if (!enable) m_mode = 0;
            else case (m_mode)
                0: if (m_go) m_mode = 1;
                1: if (!m_go) m_mode = 0;
                   else if (m_cause != 0) begin
                       m_mode = 2; m_left = HOLD_LEN; m_reason = m_cause;
                       if (m_count < 65535) m_count++;
                   end
                2: begin m_left--; if (m_left == 0) begin m_mode = 3; m_left = COOL_LEN; end end
                default: begin m_left--; if (m_left == 0) m_mode = m_go ? 1 : 0; end
            endcase

            for (int c = 0; c < NCH; c++)
                m_flag_nxt[c] = (iabs(comp_sum(2*c))   >= int'($signed(dc_th))) ||
                                (iabs(comp_sum(2*c+1)) >= int'($signed(dc_th)));
            m_flag = m_flag_nxt;

            if (iq_valid) begin
                for (int c = 0; c < NCH; c++) begin
                    for (int iq = 0; iq < 2; iq++) begin
                        m_v = int'($signed(iq_data[c*2*W + (1-iq)*W +: W]));
                        m_s = (m_v > 0) ? 1 : (m_v < 0) ? -1 : m_dither;
                        m_hist[2*c+iq].push_back(m_s);
                        if (m_hist[2*c+iq].size() > WIN) void'(m_hist[2*c+iq].pop_front());
                    end
                end
                m_dither = -m_dither;
            end

            if (!m_eqa) begin
                m_abs_i = 0; m_abs_q = 0; m_cnt_i = 0; m_cnt_q = 0;
            end else if (eq_valid) begin
                if (m_abs_i <= 2 && m_cnt_i < 63) m_cnt_i++;
                if (m_abs_q <= 2 && m_cnt_q < 63) m_cnt_q++;
                m_abs_i = iabs(int'($signed(equalizer[31:16])));
                m_abs_q = iabs(int'($signed(equalizer[15:0])));
            end

            m_ph = spd && (iabs(int'($signed(phase_offset))) > int'(ph_th));
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            check("wd_state",     32'(wd_state),     m_mode);
            check("receiver_rst", 32'(receiver_rst), 32'(m_mode == 2));
            check("rst_reason",   32'(rst_reason),   32'(m_reason));
            check("rst_count",    32'(rst_count),    m_count);
            check("dc_ch_flag",   32'(dc_ch_flag),   32'(m_flag));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_iq(input logic [W-1:0] i0, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            iq_valid = 1'b1; iq_data = '0; iq_data[2*W-1:W] = i0;
        end
        @(negedge clk);
        iq_valid = 1'b0; iq_data = '0;
    endtask

    task automatic pulse_len(input logic [15:0] len);
        @(negedge clk); signal_len = len; sig_valid = 1'b1;
        @(negedge clk); sig_valid = 1'b0;
    endtask

    task automatic count_rst_high(input int n, output int hi);
        hi = 0;
        repeat (n) begin @(negedge clk); if (receiver_rst) hi++; end
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- directed stimulus ----------------
    int hi, max_abs;
    initial begin
        enable = 1; power_trigger = 1; iq_valid = 0; sig_valid = 0; eq_valid = 0; spd = 0;
        iq_data = '0; ch_mask = 2'b01; monitor_mask = 4'hF; signal_len = 16'd100;
        min_th = 16'd0; max_th = 16'hFFFF; dc_th = 8'd2; rx_state = 5'd0;
        equalizer = '0; eq_th = 6'd16; phase_offset = '0; ph_th = 17'd20000;

        repeat (3) @(negedge clk);
        check("reset_wd_state", 32'(wd_state), 0);
        check("reset_receiver_rst", 32'(receiver_rst), 0);
        check("reset_rst_reason", 32'(rst_reason), 0);
        check("reset_rst_count", 32'(rst_count), 0);
        check("reset_dc_ch_flag", 32'(dc_ch_flag), 0);
        rst = 1'b0;

        // All-zero IQ: dither keeps every sum within +-1, so threshold 2 never trips.
        max_abs = 0; hi = 0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            iq_valid = 1'b1; iq_data = '0;
            if (receiver_rst) hi++;
            for (int k = 0; k < 2*NCH; k++)
                if (iabs(comp_sum(k)) > max_abs) max_abs = iabs(comp_sum(k));
        end
        @(negedge clk); iq_valid = 1'b0;
        check("zero_iq_model_sum_bound", max_abs, 1);
        check("zero_iq_no_receiver_rst", hi, 0);
        check("zero_iq_armed", 32'(wd_state), 1);

        // Channel 0 I at +100 for 64 valids -> DC reset.
        dc_th = 8'd64;
        send_iq(16'd100, 64);
        count_rst_high(10, hi);
        check("dc_rst_high_cycles", hi, 4);
        check("dc_flag", 32'(dc_ch_flag), 32'b01);
        check("dc_reason", 32'(rst_reason), 32'b0001);
        check("dc_count", 32'(rst_count), 1);
        send_iq(16'd0, 100);
        check("dc_no_retrigger", 32'(rst_count), 1);

        // Short length -> reset; second short length during cooldown is ignored.
        min_th = 16'd14;
        pulse_len(16'd5);
        repeat (8) @(negedge clk);
        pulse_len(16'd5);
        repeat (3) @(negedge clk);
        check("len_reason", 32'(rst_reason), 32'b0010);
        check("len_cooldown_ignored", 32'(rst_count), 2);
        repeat (25) @(negedge clk);

        // Equalizer {1,-2} for 20 samples in S_DECODE_SIGNAL, threshold 16.
        @(negedge clk); rx_state = S_DECODE_SIGNAL;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk); eq_valid = 1'b1; equalizer = {16'd1, 16'hFFFE};
        end
        @(negedge clk); eq_valid = 1'b0; rx_state = 5'd0;
        repeat (3) @(negedge clk);
        check("eq_reason", 32'(rst_reason), 32'b0100);
        check("eq_count", 32'(rst_count), 3);
        repeat (30) @(negedge clk);
        check("eq_cleared_no_retrigger", 32'(rst_count), 3);
        check("eq_back_armed", 32'(wd_state), 1);

        // Phase -32768 vs 20000: masked out first, then enabled.
        @(negedge clk); monitor_mask = 4'b0111; phase_offset = 16'h8000; spd = 1'b1;
        repeat (10) @(negedge clk);
        check("phase_masked_no_reset", 32'(rst_count), 3);
        monitor_mask = 4'b1111;
        repeat (3) @(negedge clk);
        check("phase_reason", 32'(rst_reason), 32'b1000);
        check("phase_count", 32'(rst_count), 4);
        spd = 1'b0;
        repeat (25) @(negedge clk);

        // enable dropped during HOLD -> IDLE and receiver_rst low next cycle.
        pulse_len(16'd5);
        @(negedge clk); enable = 1'b0;
        @(negedge clk);
        check("enable_low_idle", 32'(wd_state), 0);
        check("enable_low_rst_off", 32'(receiver_rst), 0);
        check("enable_low_count", 32'(rst_count), 5);
        enable = 1'b1;
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of HOLD.
        pulse_len(16'd5);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_receiver_rst", 32'(receiver_rst), 0);
        check("async_rst_wd_state", 32'(wd_state), 0);
        check("async_rst_count", 32'(rst_count), 0);
        @(negedge clk); rst = 1'b0;
        repeat (5) @(negedge clk);
        check("after_reset_armed", 32'(wd_state), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
